// File: rtl/common_pkg.sv
// Core-wide scalar types and the default boot address.
package common;
    typedef logic [31:0] word_t;
    typedef logic [63:0] addr_t;

    localparam addr_t DEFAULT_RESET_PC = 64'h8000_0000;
endpackage

// File: rtl/pipes_pkg.sv
// Pipeline-register payloads and instruction-bus bundles.
package pipes;
    import common::*;

    typedef struct packed {
        addr_t pc;
        word_t raw_instr;
        logic  cc;
    } fetch_data_t;

    typedef struct packed {
        logic  valid;
        addr_t addr;
    } ibus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } ibus_resp_t;

    // Observation of the fetch FSM: state encoding 0=FETCH, 1=HOLD, 2=DROP.
    typedef struct packed {
        logic [1:0] state;
        logic       req_active;
        logic       addr_acked;
    } fetch_debug_t;
endpackage

// File: rtl/fetch_unit_pc_gen.sv
// Fetch program counter: reset load, redirect override, sequential +4 advance.
module pc_gen
    import common::*;
#(
    parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        advance,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic [63:0] pc
);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= redirect_pc;
        end else if (advance) begin
            pc <= pc + 64'd4;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the instruction-bus handshake, fills dataF.
// Build option FETCH_PREFETCH_EN adds a one-entry buffer that keeps fetching while dataF is stalled.
module fetch_unit
    import common::*;
    import pipes::*;
#(
    parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic         clk,
    input  logic         reset,
    output logic         ireq_valid,
    output logic [63:0]  ireq_addr,
    input  logic         iresp_addr_ok,
    input  logic         iresp_data_ok,
    input  logic [31:0]  iresp_data,
    input  logic         stall,
    input  logic         redirect,
    input  logic [63:0]  redirect_pc,
    output fetch_data_t  dataF,
    output fetch_debug_t debug
);

    typedef enum logic [1:0] {S_FETCH = 2'd0, S_HOLD = 2'd1, S_DROP = 2'd2} state_e;

`ifdef FETCH_PREFETCH_EN
    localparam bit PREFETCH_EN = 1'b1;
`else
    localparam bit PREFETCH_EN = 1'b0;
`endif

    state_e      state_q, state_d;
    fetch_data_t data_q, data_d, buf_q, buf_d, fetched;
    addr_t       pc, drop_addr_q, drop_addr_d;
    logic        req_active_q, req_active_d, addr_acked_q, addr_acked_d;
    logic        req_valid, advance, accept, drain, full;
    ibus_req_t   req;
    ibus_resp_t  resp;

    // Handshake: once raised, ireq_valid/ireq_addr hold until iresp_data_ok ends the
    // transfer (iresp_addr_ok only reports address acceptance); dataF is taken on any
    // cycle with dataF.cc=1 and stall=0.
    assign resp = '{addr_ok: iresp_addr_ok, data_ok: iresp_data_ok, data: iresp_data};

    pc_gen #(.RESET_PC(RESET_PC)) u_pc_gen (
        .clk         (clk),
        .reset       (reset),
        .advance     (advance),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc          (pc)
    );

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        buf_d       = buf_q;
        drop_addr_d = drop_addr_q;
        advance     = 1'b0;
        req_valid   = 1'b0;
        accept      = data_q.cc & ~stall;
        drain       = ~data_q.cc | accept;
        full        = data_q.cc & stall & (~PREFETCH_EN | buf_q.cc);
        fetched     = '{pc: pc, raw_instr: resp.data, cc: 1'b1};

        if (drain) begin
            data_d = buf_q;
            buf_d  = '0;
        end

        unique case (state_q)
            S_FETCH: begin
                // A new request is not started while every slot is held; a response that
                // still finds no room is dropped and the same PC is fetched again.
                req_valid = req_active_q | ~full;
                if (!req_valid) begin
                    state_d = S_HOLD;
                end else if (resp.data_ok) begin
                    if (drain && !buf_q.cc) begin
                        data_d  = fetched;
                        advance = 1'b1;
                    end else if (PREFETCH_EN && (drain || !buf_q.cc)) begin
                        buf_d   = fetched;
                        advance = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (!full) state_d = S_FETCH;
            end
            S_DROP: begin
                req_valid = 1'b1;
                if (resp.data_ok) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        if (redirect) begin
            data_d  = '0;
            buf_d   = '0;
            advance = 1'b0;
            if (state_q == S_FETCH && req_valid && !resp.data_ok) begin
                state_d     = S_DROP;
                drop_addr_d = pc;
            end else if (state_q != S_DROP) begin
                state_d = S_FETCH;
            end
        end

        req_active_d = req_valid & ~resp.data_ok;
        addr_acked_d = req_valid & (addr_acked_q | resp.addr_ok) & ~resp.data_ok;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_FETCH;
            data_q       <= '0;
            buf_q        <= '0;
            drop_addr_q  <= '0;
            req_active_q <= 1'b0;
            addr_acked_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            buf_q        <= buf_d;
            drop_addr_q  <= drop_addr_d;
            req_active_q <= req_active_d;
            addr_acked_q <= addr_acked_d;
        end
    end

    assign req        = '{valid: req_valid & ~reset, addr: (state_q == S_DROP) ? drop_addr_q : pc};
    assign ireq_valid = req.valid;
    assign ireq_addr  = req.addr;
    assign dataF      = data_q;
    assign debug      = '{state: state_q, req_active: req_active_q, addr_acked: addr_acked_q};

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: scripted bus responses, expected-instruction queue.
`timescale 1ns/1ps
module tb_fetch_unit;
    import common::*;
    import pipes::*;

    localparam logic [63:0] BOOT_PC = 64'h8000_0000;

    logic         clk = 1'b0;
    logic         reset;
    logic         ireq_valid;
    logic [63:0]  ireq_addr;
    logic         iresp_addr_ok;
    logic         iresp_data_ok;
    logic [31:0]  iresp_data;
    logic         stall;
    logic         redirect;
    logic [63:0]  redirect_pc;
    fetch_data_t  dataF;
    fetch_debug_t debug;

    int          checks = 0;
    int          errors = 0;
    logic [95:0] exp_q[$];
    logic [63:0] exp_pc;

    fetch_unit #(.RESET_PC(BOOT_PC)) dut (
        .clk           (clk),
        .reset         (reset),
        .ireq_valid    (ireq_valid),
        .ireq_addr     (ireq_addr),
        .iresp_addr_ok (iresp_addr_ok),
        .iresp_data_ok (iresp_data_ok),
        .iresp_data    (iresp_data),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .dataF         (dataF),
        .debug         (debug)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; iresp_addr_ok = 1'b0; iresp_data_ok = 1'b0; iresp_data = '0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        #1;
        checks++;
        if (ireq_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid_during: got %b, expected 0", ireq_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (dataF !== '0) begin
            errors++; $display("FAIL reset_dataF: got %h, expected 0", dataF);
        end
        checks++;
        if (ireq_addr !== BOOT_PC) begin
            errors++; $display("FAIL reset_pc: got %h, expected %h", ireq_addr, BOOT_PC);
        end
        checks++;
        if (ireq_valid !== 1'b0 || debug.state !== 2'd0) begin
            errors++; $display("FAIL reset_state: got valid=%b state=%0d, expected valid=0 state=0",
                               ireq_valid, debug.state);
        end
        exp_q.delete();
        exp_pc = BOOT_PC;
    endtask

    // ---------------- driver tasks + scoreboard monitor ----------------
    task automatic drive(input bit dok, input bit aok, input bit stl, input bit red,
                         input logic [63:0] rpc, input logic [31:0] word);
        logic [95:0] exp_v;
        @(negedge clk);
        reset = 1'b0; iresp_data_ok = dok; iresp_addr_ok = aok; stall = stl;
        redirect = red; redirect_pc = rpc; iresp_data = word;
        #1;
        if (dataF.cc === 1'b1 && stall === 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_extra: got pc=%h instr=%h, expected no instruction",
                         dataF.pc, dataF.raw_instr);
            end else begin
                exp_v = exp_q.pop_front();
                if ({dataF.pc, dataF.raw_instr} !== exp_v) begin
                    errors++;
                    $display("FAIL scoreboard_data: got pc=%h instr=%h, expected pc=%h instr=%h",
                             dataF.pc, dataF.raw_instr, exp_v[95:32], exp_v[31:0]);
                end
            end
        end
    endtask

    // One bus cycle at the model PC: request must be up at exp_pc; dok answers it.
    task automatic fetch_cycle(input bit dok, input bit stl);
        logic [31:0] word;
        word = $urandom;
        drive(dok, dok, stl, 1'b0, '0, word);
        checks++;
        if (ireq_valid !== 1'b1 || ireq_addr !== exp_pc) begin
            errors++;
            $display("FAIL fetch_addr: got valid=%b addr=%h, expected valid=1 addr=%h",
                     ireq_valid, ireq_addr, exp_pc);
        end
        if (dok) begin
            exp_q.push_back({exp_pc, word});
            exp_pc = exp_pc + 64'd4;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        checks++;
        if (ireq_valid !== 1'b1 || ireq_addr !== BOOT_PC) begin
            errors++;
            $display("FAIL first_request: got valid=%b addr=%h, expected valid=1 addr=%h",
                     ireq_valid, ireq_addr, BOOT_PC);
        end
    endtask

    task automatic test_basic();
        fetch_data_t want;
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b0, '0, 32'h0000_0013);
        checks++;
        if (ireq_valid !== 1'b1 || ireq_addr !== BOOT_PC) begin
            errors++;
            $display("FAIL basic_addr: got valid=%b addr=%h, expected valid=1 addr=%h",
                     ireq_valid, ireq_addr, BOOT_PC);
        end
        exp_q.push_back({BOOT_PC, 32'h0000_0013});
        exp_pc = BOOT_PC + 64'd4;
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        want = '{pc: BOOT_PC, raw_instr: 32'h0000_0013, cc: 1'b1};
        checks++;
        if (dataF !== want) begin
            errors++; $display("FAIL basic_dataF: got %h, expected %h", dataF, want);
        end
        checks++;
        if (ireq_addr !== BOOT_PC + 64'd4) begin
            errors++; $display("FAIL basic_next_addr: got %h, expected %h", ireq_addr, BOOT_PC + 64'd4);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) fetch_cycle(1'b1, 1'b0);
    endtask

    task automatic test_stall();
        logic [63:0] held;
        held = exp_pc - 64'd4;
        for (int i = 0; i < 3; i++) begin
`ifdef FETCH_PREFETCH_EN
            if (i == 0) begin
                fetch_cycle(1'b1, 1'b1);
            end else begin
                drive(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
                checks++;
                if (ireq_valid !== 1'b0) begin
                    errors++; $display("FAIL stall_valid: got %b, expected 0 (cycle %0d)", ireq_valid, i);
                end
            end
`else
            drive(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
            checks++;
            if (ireq_valid !== 1'b0) begin
                errors++; $display("FAIL stall_valid: got %b, expected 0 (cycle %0d)", ireq_valid, i);
            end
`endif
            checks++;
            if (dataF.cc !== 1'b1 || dataF.pc !== held) begin
                errors++;
                $display("FAIL stall_hold: got cc=%b pc=%h, expected cc=1 pc=%h", dataF.cc, dataF.pc, held);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++) fetch_cycle(1'b1, 1'b0);
    endtask

    task automatic test_redirect_drop();
        logic [63:0] old_pc;
        old_pc = exp_pc;
        drive(1'b0, 1'b1, 1'b0, 1'b1, 64'h8000_0100, '0);
        checks++;
        if (ireq_valid !== 1'b1 || ireq_addr !== old_pc) begin
            errors++; $display("FAIL drop_first: got valid=%b addr=%h, expected valid=1 addr=%h",
                               ireq_valid, ireq_addr, old_pc);
        end
        exp_pc = 64'h8000_0100;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
            checks++;
            if (ireq_valid !== 1'b1 || ireq_addr !== old_pc || dataF.cc !== 1'b0) begin
                errors++;
                $display("FAIL drop_hold: got valid=%b addr=%h cc=%b, expected valid=1 addr=%h cc=0",
                         ireq_valid, ireq_addr, dataF.cc, old_pc);
            end
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 32'hdead_beef);
        checks++;
        if (ireq_addr !== old_pc) begin
            errors++; $display("FAIL drop_done_addr: got %h, expected %h", ireq_addr, old_pc);
        end
        fetch_cycle(1'b1, 1'b0);
        checks++;
        if (dataF.cc !== 1'b0) begin
            errors++; $display("FAIL drop_discard: got cc=%b, expected 0", dataF.cc);
        end
    endtask

    task automatic test_redirect_same();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 64'h8000_0180, $urandom);
        checks++;
        if (ireq_valid !== 1'b1 || ireq_addr !== exp_pc) begin
            errors++; $display("FAIL same_addr: got valid=%b addr=%h, expected valid=1 addr=%h",
                               ireq_valid, ireq_addr, exp_pc);
        end
        exp_pc = 64'h8000_0180;
        fetch_cycle(1'b1, 1'b0);
        checks++;
        if (dataF.cc !== 1'b0) begin
            errors++; $display("FAIL same_discard: got cc=%b, expected 0", dataF.cc);
        end
    endtask

    task automatic test_double_redirect();
        logic [63:0] old_pc;
        old_pc = exp_pc;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 64'h8000_0200, '0);
        checks++;
        if (ireq_addr !== old_pc) begin
            errors++; $display("FAIL dbl_first: got %h, expected %h", ireq_addr, old_pc);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 64'h8000_0300, '0);
        checks++;
        if (ireq_addr !== old_pc || debug.state !== 2'd2) begin
            errors++; $display("FAIL dbl_second: got addr=%h state=%0d, expected addr=%h state=2",
                               ireq_addr, debug.state, old_pc);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, $urandom);
        checks++;
        if (ireq_addr !== old_pc) begin
            errors++; $display("FAIL dbl_done_addr: got %h, expected %h", ireq_addr, old_pc);
        end
        exp_pc = 64'h8000_0300;
        fetch_cycle(1'b1, 1'b0);
        checks++;
        if (dataF.cc !== 1'b0) begin
            errors++; $display("FAIL dbl_discard: got cc=%b, expected 0", dataF.cc);
        end
    endtask

    task automatic test_reset_hold();
        fetch_cycle(1'b1, 1'b0);
`ifdef FETCH_PREFETCH_EN
        fetch_cycle(1'b1, 1'b1);
`endif
        drive(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
        checks++;
        if (debug.state !== 2'd1 || dataF.cc !== 1'b1 || ireq_valid !== 1'b0) begin
            errors++; $display("FAIL hold_state: got state=%0d cc=%b valid=%b, expected state=1 cc=1 valid=0",
                               debug.state, dataF.cc, ireq_valid);
        end
        do_reset();
        fetch_cycle(1'b1, 1'b0);
    endtask

    task automatic test_random_latency();
        for (int n = 0; n < 16; n++) begin
            int wait_cycles;
            wait_cycles = $urandom_range(0, 2);
            for (int w = 0; w < wait_cycles; w++) fetch_cycle(1'b0, 1'b0);
            fetch_cycle(1'b1, 1'b0);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        reset = 1'b1; iresp_addr_ok = 1'b0; iresp_data_ok = 1'b0; iresp_data = '0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        exp_pc = BOOT_PC;
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_redirect_drop();
        test_redirect_same();
        test_double_redirect();
        test_reset_hold();
        test_random_latency();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
